amostrador_entradas: RTL and testbench

//  Input stage that sits directly upstream of the 8-bit subtractor chain and drives its A bus.

---
 rtl/amostrador_entradas_pkg.sv | 13 +
 rtl/amostrador_entradas_if.sv | 25 ++
 rtl/amostrador_entradas_sincronizador_2ff.sv | 26 ++
 rtl/amostrador_entradas.sv | 102 ++++++++++
 tb/tb_amostrador_entradas.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/amostrador_entradas_pkg.sv
// Shared types and default sizing for the input sampler feeding the subtractor A bus.
package pacote_amostrador;

  typedef enum logic {
    ESTAVEL  = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  localparam int LARGURA_PADRAO  = 8;
  localparam int DEBOUNCE_PADRAO = 16;
  localparam int CONT_W_PADRAO   = 5;

endpackage

// File: rtl/amostrador_entradas_if.sv
// Operand bus between the switch sampler and the subtractor: raw lines in, settled A plus valid/ack out.
interface amostrador_entradas_if
  import pacote_amostrador::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);

  logic [LARGURA-1:0] chaves;
  logic               habilita;
  logic               ack;
  logic [LARGURA-1:0] A;
  logic               valido;
  logic               sobrescrito;

  modport master (
    output chaves, habilita, ack,
    input  A, valido, sobrescrito
  );

  modport slave (
    input  chaves, habilita, ack,
    output A, valido, sobrescrito
  );

endinterface

// File: rtl/amostrador_entradas_sincronizador_2ff.sv
// Two-flop synchroniser, one chain per bit; the only logic that ever sees the raw inputs.
module sincronizador_2ff #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] d_i,
  output logic [LARGURA-1:0] q_o
);

  logic [LARGURA-1:0] meta_q;
  logic [LARGURA-1:0] sinc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/amostrador_entradas.sv
// Synchronises and debounces the switch vector as a whole, then publishes it on A with valid/ack.
module amostrador_entradas
  import pacote_amostrador::*;
#(
  parameter int LARGURA         = LARGURA_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int CONT_W          = CONT_W_PADRAO
) (
  input logic                  clk,
  input logic                  rst,
  amostrador_entradas_if.slave bus
);

  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic [LARGURA-1:0] sinc;
  logic [LARGURA-1:0] cand_q;
  logic [LARGURA-1:0] a_q;
  logic [CONT_W-1:0]  cont_q;
  estado_t            estado_q;
  logic               publica;
  logic               valido_q, valido_d;
  logic               sobre_q, sobre_d;

  sincronizador_2ff #(
    .LARGURA(LARGURA)
  ) u_sinc (
    .clk (clk),
    .rst (rst),
    .d_i (bus.chaves),
    .q_o (sinc)
  );

  // Same condition the FSM uses to load A; shared so the flags move on exactly that edge.
  assign publica = (estado_q == CONTANDO) && (sinc == cand_q) && (sinc != a_q) &&
                   bus.habilita && (cont_q == CONT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESTAVEL;
      cand_q   <= '0;
      cont_q   <= '0;
      a_q      <= '0;
    end else begin
      case (estado_q)
        ESTAVEL: begin
          if (sinc != a_q) begin
            cand_q   <= sinc;
            cont_q   <= '0;
            estado_q <= CONTANDO;
          end
        end
        CONTANDO: begin
          if (sinc != cand_q) begin
            cand_q <= sinc;
            cont_q <= '0;
          end else if (sinc == a_q) begin
            estado_q <= ESTAVEL;
            cont_q   <= '0;
          end else if (bus.habilita) begin
            if (cont_q == CONT_MAX) begin
              a_q      <= cand_q;
              cont_q   <= '0;
              estado_q <= ESTAVEL;
            end else begin
              cont_q <= cont_q + 1'b1;
            end
          end
        end
        default: estado_q <= ESTAVEL;
      endcase
    end
  end

  // A publish beats a simultaneous ack; sobrescrito only tracks data lost while unacked.
  always_comb begin
    valido_d = valido_q;
    sobre_d  = sobre_q;
    if (publica) begin
      valido_d = 1'b1;
      if (valido_q) sobre_d = !bus.ack;
    end else if (bus.ack && valido_q) begin
      valido_d = 1'b0;
      sobre_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valido_q <= 1'b0;
      sobre_q  <= 1'b0;
    end else begin
      valido_q <= valido_d;
      sobre_q  <= sobre_d;
    end
  end

  assign bus.A           = a_q;
  assign bus.valido      = valido_q;
  assign bus.sobrescrito = sobre_q;

endmodule

// File: tb/tb_amostrador_entradas.sv
// Directed bench for amostrador_entradas: debounce latency, bounce rejection, overwrite and handshake.
module tb_amostrador_entradas;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic subiu;

  amostrador_entradas_if #(.LARGURA(8)) bus ();

  amostrador_entradas dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.chaves   = 8'hFF;
    bus.habilita = 1'b1;
    bus.ack      = 1'b0;

    // 1: reset
    ticks(2);
    chk("rst_A", bus.A, 8'h00);
    chk("rst_valido", {7'd0, bus.valido}, 8'd0);
    chk("rst_sobrescrito", {7'd0, bus.sobrescrito}, 8'd0);
    rst        = 1'b0;
    bus.chaves = 8'h00;
    ticks(5);
    chk("idle_valido", {7'd0, bus.valido}, 8'd0);

    // 2: first publish, 19 edges after the change
    bus.chaves = 8'hA5;
    ticks(18);
    chk("lat18_valido", {7'd0, bus.valido}, 8'd0);
    chk("lat18_A", bus.A, 8'h00);
    tick();
    chk("lat19_valido", {7'd0, bus.valido}, 8'd1);
    chk("lat19_A", bus.A, 8'hA5);
    do_ack();
    chk("ack_valido", {7'd0, bus.valido}, 8'd0);
    chk("ack_A_held", bus.A, 8'hA5);

    // 3: 10-cycle glitch is rejected
    subiu      = 1'b0;
    bus.chaves = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      subiu |= bus.valido;
    end
    bus.chaves = 8'hA5;
    for (int i = 0; i < 30; i++) begin
      tick();
      subiu |= bus.valido;
    end
    chk("glitch_valido_never", {7'd0, subiu}, 8'd0);
    chk("glitch_A", bus.A, 8'hA5);

    // 4: overwrite without ack
    bus.chaves = 8'h0F;
    ticks(19);
    chk("ow1_A", bus.A, 8'h0F);
    chk("ow1_sobrescrito", {7'd0, bus.sobrescrito}, 8'd0);
    bus.chaves = 8'hF0;
    ticks(19);
    chk("ow2_A", bus.A, 8'hF0);
    chk("ow2_valido", {7'd0, bus.valido}, 8'd1);
    chk("ow2_sobrescrito", {7'd0, bus.sobrescrito}, 8'd1);
    do_ack();
    chk("ow_ack_valido", {7'd0, bus.valido}, 8'd0);
    chk("ow_ack_sobrescrito", {7'd0, bus.sobrescrito}, 8'd0);

    // 4b: publish and ack on the same edge, new data wins
    bus.chaves = 8'hC3;
    ticks(19);
    chk("same_pre_A", bus.A, 8'hC3);
    bus.chaves = 8'h3C;
    ticks(18);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("same_A", bus.A, 8'h3C);
    chk("same_valido", {7'd0, bus.valido}, 8'd1);
    chk("same_sobrescrito", {7'd0, bus.sobrescrito}, 8'd0);
    do_ack();
    chk("same_ack_valido", {7'd0, bus.valido}, 8'd0);

    // 5: habilita low for 20 cycles mid-count
    bus.chaves = 8'h77;
    ticks(8);
    bus.habilita = 1'b0;
    ticks(20);
    bus.habilita = 1'b1;
    ticks(10);
    chk("hab38_valido", {7'd0, bus.valido}, 8'd0);
    chk("hab38_A", bus.A, 8'h3C);
    tick();
    chk("hab39_valido", {7'd0, bus.valido}, 8'd1);
    chk("hab39_A", bus.A, 8'h77);
    do_ack();

    // 6: reset at count 8 discards the count
    bus.chaves = 8'h33;
    ticks(11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_A", bus.A, 8'h00);
    chk("midrst_valido", {7'd0, bus.valido}, 8'd0);
    ticks(18);
    chk("post_rst18_valido", {7'd0, bus.valido}, 8'd0);
    tick();
    chk("post_rst19_valido", {7'd0, bus.valido}, 8'd1);
    chk("post_rst19_A", bus.A, 8'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
